// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage behind the ALU operation units. Each ALU result
// (with carry and op tag) is captured through a valid/ready handshake into a
// 2-entry FIFO. Zero/negative/parity flags are computed once at capture and
// stored with the entry. A sticky carry flag and a saturating count of
// delivered results are kept for status reporting.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake
//   in_result/in_carry   ALU result (2*WIDTH bits) and carry_out
//   in_op                opaque 2-bit op tag carried with the result
//   out_valid/out_ready  consumer handshake
//   out_result/out_carry/out_op  head entry (all zero when empty)
//   out_zero/out_neg/out_parity  flags stored with the head entry
//   clr_status           synchronous clear of sticky_carry and done_count
//   sticky_carry         set once any delivered entry had carry = 1
//   done_count           number of delivered entries, saturating
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_result,
    input  logic                 in_carry,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_carry,
    output logic [1:0]           out_op,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_parity,
    input  logic                 clr_status,
    output logic                 sticky_carry,
    output logic [CNT_W-1:0]     done_count
);

    localparam int RW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [RW-1:0] result;
        logic          carry;
        logic [1:0]    op;
        logic          zero;
        logic          neg;
        logic          parity;
    } entry_t;

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    entry_t     in_entry;
    entry_t     head;

    // Handshake depends only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags are derived from the incoming result and frozen with the entry.
    always_comb begin
        // NOTE: every field gets a value on every path; a missing assignment
        // in a combinational block would infer a latch.
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.carry  = in_carry;
        in_entry.op     = in_op;
        in_entry.zero   = (in_result == '0);
        in_entry.neg    = in_result[RW-1];
        in_entry.parity = ^in_result;
    end

    // Empty FIFO presents all-zero data rather than a stale entry.
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_result = head.result;
    assign out_carry  = head.carry;
    assign out_op     = head.op;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_parity = head.parity;

    // NOTE: the storage is only two entries, so it is reset like ordinary
    // flops; this guarantees all-zero contents straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            // NOTE: non-blocking assignments for all clocked state so every
            // register samples pre-edge values regardless of block order.
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers are 1 bit wide, so increment wraps modulo 2 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A pop in the same cycle as clr_status is not lost: the clear discards
    // history, then the pop's contribution is applied on top of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry <= 1'b0;
            done_count   <= '0;
        end else if (pop) begin
            if (clr_status) begin
                sticky_carry <= head.carry;
                done_count   <= CNT_ONE;
            end else begin
                sticky_carry <= sticky_carry | head.carry;
                if (done_count != CNT_MAX) done_count <= done_count + CNT_ONE;
            end
        end else if (clr_status) begin
            sticky_carry <= 1'b0;
            done_count   <= '0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed and randomized stimulus for alu_result_stage. Expected values come
// from a queue-based model of the FIFO plus plain integer status counters.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_carry;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic [1:0] out_op;
    logic       out_zero;
    logic       out_neg;
    logic       out_parity;
    logic       clr_status;
    logic       sticky_carry;
    logic [7:0] done_count;

    alu_result_stage #(.WIDTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_op       (out_op),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_parity   (out_parity),
        .clr_status   (clr_status),
        .sticky_carry (sticky_carry),
        .done_count   (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic [1:0] op;
    } item_t;

    item_t q[$];
    int    sticky_m;
    int    done_m;
    int    checks;
    int    failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        item_t h;
        h = '{res: 8'h00, c: 1'b0, op: 2'b00};
        if (q.size() != 0) h = q[0];
        chk("in_ready",     32'(in_ready),     32'(q.size() != 2));
        chk("out_valid",    32'(out_valid),    32'(q.size() != 0));
        chk("out_result",   32'(out_result),   32'(h.res));
        chk("out_carry",    32'(out_carry),    32'(h.c));
        chk("out_op",       32'(out_op),       32'(h.op));
        chk("out_zero",     32'(out_zero),     32'(q.size() != 0 && h.res == 0));
        chk("out_neg",      32'(out_neg),      32'(h.res >= 8'h80));
        chk("out_parity",   32'(out_parity),   32'($countones(h.res) % 2));
        chk("sticky_carry", 32'(sticky_carry), 32'(sticky_m));
        chk("done_count",   32'(done_count),   32'(done_m));
    endtask

    // One clock: the model decides push/pop from pre-edge state, updates at
    // the edge, and all outputs are compared 1 time unit later.
    task automatic cycle();
        bit    push_m;
        bit    pop_m;
        item_t it;
        push_m = in_valid && (q.size() != 2);
        pop_m  = out_ready && (q.size() != 0);
        @(posedge clk);
        if (pop_m) begin
            it = q.pop_front();
            if (clr_status) begin
                sticky_m = int'(it.c);
                done_m   = 1;
            end else begin
                if (it.c) sticky_m = 1;
                done_m = (done_m < 255) ? done_m + 1 : 255;
            end
        end else if (clr_status) begin
            sticky_m = 0;
            done_m   = 0;
        end
        if (push_m) q.push_back('{res: in_result, c: in_carry, op: in_op});
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic c,
                         input logic [1:0] op, input logic ordy, input logic clr);
        in_valid   = v;
        in_result  = r;
        in_carry   = c;
        in_op      = op;
        out_ready  = ordy;
        clr_status = clr;
    endtask

    task automatic model_reset();
        q.delete();
        sticky_m = 0;
        done_m   = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // Reset state
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero result: flags and first delivery
        drive(1'b1, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0);
        cycle();
        chk("zero_valid",  32'(out_valid),  32'd1);
        chk("zero_flag",   32'(out_zero),   32'd1);
        chk("zero_parity", 32'(out_parity), 32'd0);
        chk("zero_neg",    32'(out_neg),    32'd0);
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        cycle();
        chk("zero_done",   32'(done_count),   32'd1);
        chk("zero_sticky", 32'(sticky_carry), 32'd0);

        // Fill to 2 with consumer stalled
        drive(1'b1, 8'h81, 1'b0, 2'd2, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h07, 1'b0, 2'd3, 1'b0, 1'b0);
        cycle();
        chk("full_in_ready", 32'(in_ready),   32'd0);
        chk("full_head",     32'(out_result), 32'h81);
        chk("full_neg",      32'(out_neg),    32'd1);
        chk("full_parity",   32'(out_parity), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        cycle();
        chk("pop1_head",     32'(out_result), 32'h07);
        chk("pop1_parity",   32'(out_parity), 32'd1);
        chk("pop1_in_ready", 32'(in_ready),   32'd1);
        cycle();

        // Clear, then stream 10 results back-to-back
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'($urandom_range(255)), 1'($urandom_range(1)),
                  2'($urandom_range(3)), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        cycle();
        chk("stream_done", 32'(done_count), 32'd10);

        // Simultaneous push and pop at count == 1
        drive(1'b1, 8'h33, 1'b0, 2'd1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h0F, 1'b0, 2'd2, 1'b1, 1'b0);
        cycle();
        chk("pp_head",     32'(out_result), 32'h0F);
        chk("pp_valid",    32'(out_valid),  32'd1);
        chk("pp_in_ready", 32'(in_ready),   32'd1);
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        cycle();

        // Pop with carry while clearing: the pop wins
        drive(1'b1, 8'h55, 1'b1, 2'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1);
        cycle();
        chk("clrpop_sticky", 32'(sticky_carry), 32'd1);
        chk("clrpop_done",   32'(done_count),   32'd1);
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        cycle();
        chk("clr_sticky", 32'(sticky_carry), 32'd0);
        chk("clr_done",   32'(done_count),   32'd0);

        // Randomized traffic; producer holds data while stalled
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (!(in_valid && q.size() == 2)) begin
                in_valid  = 1'($urandom_range(1));
                in_result = 8'($urandom_range(255));
                in_carry  = 1'($urandom_range(1));
                in_op     = 2'($urandom_range(3));
            end
            out_ready  = ($urandom_range(3) != 0);
            clr_status = ($urandom_range(15) == 0);
            cycle();
        end

        // Asynchronous reset with the FIFO full
        drive(1'b1, 8'hA5, 1'b1, 2'd1, 1'b0, 1'b0);
        cycle();
        cycle();
        cycle();
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid",    32'(out_valid),  32'd0);
        chk("rst_in_ready", 32'(in_ready),   32'd1);
        check_all();
        #1;
        rst_n = 1'b1;

        // Saturation of the delivered counter
        drive(1'b1, 8'h11, 1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            in_result = 8'($urandom_range(255));
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        cycle();
        chk("sat_done", 32'(done_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
